// File: rtl/alu_seq.sv
// alu_seq: sequential ALU; single-cycle logic/add/sub, iterative shift-add multiply and restoring divide.
// Latency: 1 cycle for single-cycle ops (done the cycle after accept); WIDTH cycles for mul/div.
// Backpressure: ready=0 while mul/div iterate; start without ready is dropped. Optional divider: `define ALU_DIV_EN.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [3:0]       ctrl,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             z_flag,
    output logic             n_flag,
    output logic             v_flag,
    output logic             c_flag,
    output logic             dz_flag,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_mcand, r_prod, w_prod_sum;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_out;
    logic                 r_done, r_z, r_n, r_v, r_c, r_err;
    logic                 w_acc, w_last, w_load;
    logic [WIDTH-1:0]     w_out;
    logic                 w_v, w_c, w_err;
    logic [WIDTH:0]       w_add, w_subr;
`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]     r_rem, r_quo, r_dvsr;
    logic                 r_is_mod, r_dz, w_dz;
    logic [WIDTH:0]       w_shift, w_trial;
    logic [WIDTH-1:0]     w_rem_nxt, w_quo_nxt;
`endif

    assign w_acc  = start && (r_state == S_IDLE);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Arithmetic helpers: add/sub with carry-out bit, one shift-add step, one restoring-divide step
    always_comb begin
        w_add      = {1'b0, ain} + {1'b0, bin};
        w_subr     = {1'b0, ain} - {1'b0, bin};
        w_prod_sum = r_prod + (r_mplier[0] ? r_mcand : '0);
`ifdef ALU_DIV_EN
        w_shift    = {r_rem, r_quo[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_dvsr};
        if (w_trial[WIDTH]) begin
            // partial remainder smaller than divisor: restore, quotient bit 0
            w_rem_nxt = w_shift[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
        end else begin
            w_rem_nxt = w_trial[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
        end
`endif
    end

    // Next state and the result/flags to register when an op completes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_out       = '0;
        w_v         = 1'b0;
        w_c         = 1'b0;
        w_err       = 1'b0;
`ifdef ALU_DIV_EN
        w_dz        = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_load = 1'b1;
                    case (ctrl)
                        4'd0: begin
                            w_out = w_add[WIDTH-1:0];
                            w_c   = w_add[WIDTH];
                            w_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (w_add[WIDTH-1] != ain[WIDTH-1]);
                        end
                        4'd1: begin
                            w_out = w_subr[WIDTH-1:0];
                            w_c   = w_subr[WIDTH];
                            w_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (w_subr[WIDTH-1] != ain[WIDTH-1]);
                        end
                        4'd2: begin
                            w_load      = 1'b0;
                            w_state_nxt = S_MUL;
                        end
`ifdef ALU_DIV_EN
                        4'd3, 4'd4: begin
                            if (bin == '0) begin
                                // divide by zero resolves immediately
                                w_out = (ctrl == 4'd3) ? '1 : ain;
                                w_dz  = 1'b1;
                            end else begin
                                w_load      = 1'b0;
                                w_state_nxt = S_DIV;
                            end
                        end
`endif
                        4'd5:    w_out = ~ain;
                        4'd6:    w_out = ain & bin;
                        4'd7:    w_out = ain | bin;
                        4'd8:    w_out = ain ^ bin;
                        4'd9:    w_out = {{(WIDTH-1){1'b0}}, (ain == '0)};
                        4'd10:   w_out = {{(WIDTH-1){1'b0}}, (ain != '0) && (bin != '0)};
                        4'd11:   w_out = {{(WIDTH-1){1'b0}}, (ain != '0) || (bin != '0)};
                        default: w_err = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_load      = 1'b1;
                    w_out       = w_prod_sum[WIDTH-1:0];
                    w_v         = |w_prod_sum[2*WIDTH-1:WIDTH];
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                if (w_last) begin
                    w_load      = 1'b1;
                    w_out       = r_is_mod ? w_rem_nxt : w_quo_nxt;
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Result/flag registers, done pulse, and iterative datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_out    <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
`ifdef ALU_DIV_EN
            r_dz     <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_is_mod <= 1'b0;
`endif
        end else begin
            r_done <= w_load;
            if (w_load) begin
                r_out <= w_out;
                r_z   <= (w_out == '0);
                r_n   <= w_out[WIDTH-1];
                r_v   <= w_v;
                r_c   <= w_c;
                r_err <= w_err;
`ifdef ALU_DIV_EN
                r_dz  <= w_dz;
`endif
            end
            if (w_acc) begin
                // operands latched here so later input changes cannot disturb the iteration
                r_cnt    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, ain};
                r_mplier <= bin;
                r_prod   <= '0;
`ifdef ALU_DIV_EN
                r_rem    <= '0;
                r_quo    <= ain;
                r_dvsr   <= bin;
                r_is_mod <= (ctrl == 4'd4);
`endif
            end else if (r_state != S_IDLE) begin
                r_cnt    <= r_cnt + 1'b1;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_prod   <= w_prod_sum;
`ifdef ALU_DIV_EN
                r_rem    <= w_rem_nxt;
                r_quo    <= w_quo_nxt;
`endif
            end
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign done   = r_done;
    assign out    = r_out;
    assign z_flag = r_z;
    assign n_flag = r_n;
    assign v_flag = r_v;
    assign c_flag = r_c;
    assign err    = r_err;
`ifdef ALU_DIV_EN
    assign dz_flag = r_dz;
`else
    assign dz_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): reference results pushed at issue, monitor checks at done.
// Latency is checked against the accept cycle; busy-time starts are driven and must be ignored.
// Expectations follow the same ALU_DIV_EN setting as the design build.
module tb_alu_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  ain = '0, bin = '0;
    logic [3:0]    ctrl = '0;
    logic          ready, done, z_flag, n_flag, v_flag, c_flag, dz_flag, err;
    logic [W-1:0]  out;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ain(ain), .bin(bin), .ctrl(ctrl),
        .ready(ready), .done(done), .out(out),
        .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag), .c_flag(c_flag),
        .dz_flag(dz_flag), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [5:0]   fl;   // {z, n, v, c, dz, err}
        int           due;  // cycle count at which done is expected
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode meanings
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] op, input int acc);
        exp_t   e;
        logic [63:0] wide;
        longint s;
        logic   v, c, dz, er;
        int     lat;
        v = 0; c = 0; dz = 0; er = 0; lat = 0; e.res = '0;
        case (op)
            0: begin
                wide = 64'(a) + 64'(b);
                e.res = wide[W-1:0]; c = (wide > 64'hFFFF_FFFF);
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: begin
                e.res = a - b; c = (a < b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2: begin
                wide = 64'(a) * 64'(b);
                e.res = wide[W-1:0]; v = (wide[63:32] != 0); lat = W;
            end
`ifdef ALU_DIV_EN
            3: if (b == 0) begin e.res = '1; dz = 1; end else begin e.res = a / b; lat = W; end
            4: if (b == 0) begin e.res = a;  dz = 1; end else begin e.res = a % b; lat = W; end
`endif
            5:  e.res = ~a;
            6:  e.res = a & b;
            7:  e.res = a | b;
            8:  e.res = a ^ b;
            9:  e.res = (a == 0) ? 1 : 0;
            10: e.res = (a != 0 && b != 0) ? 1 : 0;
            11: e.res = (a != 0 || b != 0) ? 1 : 0;
            default: er = 1;
        endcase
        e.fl  = {(e.res == 0), e.res[W-1], v, c, dz, er};
        e.due = acc + lat;
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out", 64'(out), 64'(e.res));
                chk("flags_znvc_dz_err", 64'({z_flag, n_flag, v_flag, c_flag, dz_flag, err}), 64'(e.fl));
                chk("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Called at a negedge; pokes start while busy, then issues one op on the first ready cycle
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        int n = 0;
        while (!ready && n < 200) begin
            start = 1'($urandom_range(0, 1));
            ain = $urandom; bin = $urandom; ctrl = 4'($urandom);
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", 64'(ready), 64'(1));
            start = 1'b0;
            return;
        end
        start = 1'b1; ain = a; bin = b; ctrl = op;
        sbq.push_back(model(a, b, op, cyc + 1));
        @(negedge clk);
        start = 1'b0; ain = $urandom; bin = $urandom; ctrl = 4'($urandom);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return 0;
            1: return 1;
            2: return '1;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            5: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int drain;
        #3;
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_out", 64'(out), 64'(0));
        chk("rst_flags", 64'({z_flag, n_flag, v_flag, c_flag, dz_flag, err}), 64'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(32'h7FFF_FFFF, 32'h1, 4'd0);
        issue(32'hFFFF_FFFF, 32'h1, 4'd0);
        issue(32'd3, 32'd5, 4'd1);
        issue(32'h0000_F0F0, 32'h0000_0FF0, 4'd6);
        issue(32'h0001_0000, 32'h0001_0000, 4'd2);
        issue(32'd9, 32'd9, 4'd0);   // busy pokes precede this one
        issue(32'd100, 32'd7, 4'd3);
        issue(32'd100, 32'd7, 4'd4);
        issue(32'd5, 32'd0, 4'd3);
        issue(32'd5, 32'd0, 4'd4);
        issue(32'd1, 32'd2, 4'd13);
        issue(32'd0, 32'd0, 4'd9);
        issue(32'd0, 32'd4, 4'd11);
        repeat (40) @(negedge clk);

        // Reset in the middle of a multiply: aborted, no done afterwards
        issue(32'd12345, 32'd678, 4'd2);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready), 64'(1));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_out", 64'(out), 64'(0));
        chk("midrst_flags", 64'({z_flag, n_flag, v_flag, c_flag, dz_flag, err}), 64'(0));
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd12345, 32'd678, 4'd2);

        // Random ops with random gaps
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a, b;
            logic [3:0]   op;
            a = pick(); b = pick();
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 11));
            issue(a, b, op);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        drain = 0;
        while (sbq.size() != 0 && drain < 200) begin
            @(negedge clk);
            drain++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the team's combinational ALU. Accepts one operation per handshake, registers result and flags, and executes multiply and divide/modulo iteratively over WIDTH cycles instead of as single-cycle combinational arrays. Sits between the operand register file and the writeback stage: the issuer drives `start` while `ready` is high, and writeback samples `out` and the flags when `done` pulses.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted on a rising edge where start=1 and ready=1.
- ain, bin  in  WIDTH  operands, sampled only at acceptance.
- ctrl  in  4  opcode, sampled only at acceptance.
- ready  out  1  unit idle and able to accept.
- done  out  1  one-cycle pulse: out/flags updated.
- out  out  WIDTH  registered result; held until the next done.
- z_flag, n_flag, v_flag, c_flag  out  1  zero, negative, overflow, carry; registered with out.
- dz_flag  out  1  divide/modulo by zero.
- err  out  1  illegal opcode.

## Operation
- Opcodes: 0 add, 1 sub, 2 mul (low WIDTH bits, unsigned), 3 div (unsigned quotient), 4 mod (unsigned remainder), 5 bitwise NOT ain, 6 AND, 7 OR, 8 XOR, 9 logical NOT (out=1 iff ain==0), 10 logical AND, 11 logical OR; 12–15 are illegal.
- States: IDLE (ready=1), MUL, DIV. IDLE→MUL on accepted op 2. IDLE→DIV on accepted op 3/4 with bin≠0. MUL/DIV→IDLE after WIDTH iterations. All other accepted ops complete in IDLE.
- MUL: shift-add, 1 multiplier bit per cycle, 2·WIDTH-bit internal product.
- DIV: restoring, 1 quotient bit per cycle. Op 3 returns the quotient; op 4 returns the remainder.
- Flags:
  - z = (out==0); n = out[WIDTH-1].
  - add: c = carry out; v = signed overflow (operand signs equal and result sign differs).
  - sub: c = borrow (ain<bin unsigned); v = signed overflow.
  - mul: v = upper WIDTH product bits nonzero; c=0.
  - All other ops: v=c=0.
- Divide by zero: single-cycle. div gives out = all ones; mod gives out = ain. Sets dz_flag=1, v=c=0, and z/n computed from out.
- Illegal op: single-cycle, out=0, err=1, z=1, other flags 0.
- dz_flag and err are cleared on any done for which they do not apply.
- start while ready=0 is ignored and not queued.
- Operands are latched at acceptance, so later ain/bin/ctrl changes do not affect an operation in flight.

## Timing
- Reset (async assert, sync release): state=IDLE, ready=1, done=0, out=0, all flags 0. Reset mid-MUL/DIV aborts the operation, with no done pulse.
- Single-cycle ops: result registered on the accepting edge E; done=1 for the cycle after E; ready stays 1, so back-to-back accepts every cycle are allowed.
- MUL/DIV: accept at edge E; ready=0 from E until edge E+WIDTH; result registered at edge E+WIDTH; done=1 and ready=1 in the cycle after E+WIDTH. Latency is WIDTH cycles.
- A new start may be accepted in the same cycle done is high.
- done never stays high two consecutive cycles unless a new op was accepted.

## Configuration
- ALU_DIV_EN defined: DIV state, iterative divider and dz_flag logic are built.
- Not defined: no divider hardware; opcodes 3/4 behave as illegal (1 cycle, out=0, err=1); dz_flag is tied 0.

## Test plan
- Reset mid-operation: reset during MUL → ready=1, out=0, all flags 0, no done, next op completes normally.
- Adds, WIDTH=32:
  - 0x7FFFFFFF+1 → out=0x80000000, v=1, n=1, c=0.
  - 0xFFFFFFFF+1 → out=0, z=1, c=1, v=0.
- Sub 3−5 → out=0xFFFFFFFE, c=1, n=1, v=0; back-to-back with AND 0xF0F0&0x0FF0 next cycle → out=0x00F0 one cycle later.
- Mul 0x10000×0x10000 → done exactly 32 cycles after accept, out=0, z=1, v=1; a start raised while busy is ignored.
- ALU_DIV_EN:
  - div 100/7 → out=14 after 32 cycles.
  - mod 100%7 → out=2.
  - div 5/0 → out=0xFFFFFFFF, dz_flag=1, done next cycle.
- Opcode 13 → out=0, err=1, z=1. Without ALU_DIV_EN, opcode 3 → err=1 in one cycle.
